i2c_target_responder: RTL and testbench

- Synthesizable I2C target (slave) that answers the byte-level controller (CSR/DPR/CMDR/FSMR) on the shared open-drain bus.
- Decodes START, address, write data, STOP and repeated START; ACKs its own address; supplies read bytes from a local request/response port.
- Sits beside the DUT in the system-level bench as the far end of the bus.
- Oversamples SCL/SDA on the system clock.

---
 rtl/i2c_target_responder.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: address match, write capture, read supply, ACK/NACK.
// Optional I2C_GENERAL_CALL_EN: also ACK the general-call write address byte 8'h00 and flag it on gc_hit.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       op,
    output logic       start_det,
    output logic       stop_det,
`ifdef I2C_GENERAL_CALL_EN
    output logic       gc_hit,
`endif
    output logic       busy
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDRESS   = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITEDATA = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_READDATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_IGNORE    = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic       scl_d1_q, sda_d1_q;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic       rd_req_q, rd_req_d;
    logic       op_q, op_d;
    logic       busy_q, busy_d;
    logic       start_det_q, stop_det_q;
    logic       gc_q, gc_d;

    // Bus idles high, so synchronizers reset to 1 to avoid a phantom START/STOP.
    wire scl_s      = scl_sync_q[SYNC_STAGES-1];
    wire sda_s      = sda_sync_q[SYNC_STAGES-1];
    wire scl_rise   = scl_s & ~scl_d1_q;
    wire scl_fall   = ~scl_s & scl_d1_q;
    wire start_cond = scl_s & sda_d1_q & ~sda_s;
    wire stop_cond  = scl_s & ~sda_d1_q & sda_s;
    wire [7:0] rx_byte = {shift_q[6:0], sda_s};
    wire is_gc      = (rx_byte == 8'h00);
`ifdef I2C_GENERAL_CALL_EN
    wire addr_hit   = (rx_byte[7:1] == TARGET_ADDR) || is_gc;
`else
    wire addr_hit   = (rx_byte[7:1] == TARGET_ADDR);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        wr_data_d  = wr_data_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        op_d       = op_q;
        busy_d     = busy_q;
        gc_d       = gc_q;
        if (start_cond) begin
            state_d  = ST_ADDRESS;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            gc_d     = 1'b0;
        end else if (stop_cond) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            gc_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDRESS: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (addr_hit) begin
                            op_d    = rx_byte[0];
                            busy_d  = 1'b1;
                            gc_d    = is_gc;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // cnt 8 = after 8th rise (drive ACK on next fall); cnt 9 = after ACK clock rise.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ST_ADDR_ACK && op_q) rd_req_d = 1'b1;
                    end else if (cnt_q == 4'd9) begin
                        cnt_d = 4'd0;
                        if (state_q == ST_ADDR_ACK && op_q) begin
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[7];
                            state_d  = ST_READDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WRITEDATA;
                        end
                    end
                end
                ST_WRITEDATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        wr_data_d  = rx_byte;
                        wr_valid_d = 1'b1;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_READDATA: if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RD_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (sda_s) state_d = ST_IGNORE;
                    else       rd_req_d = 1'b1;
                end else if (scl_fall && cnt_q == 4'd9) begin
                    shift_d  = rd_data;
                    sda_oe_d = ~rd_data[7];
                    cnt_d    = 4'd0;
                    state_d  = ST_READDATA;
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_d1_q    <= 1'b1;
            sda_d1_q    <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            wr_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            op_q        <= 1'b0;
            busy_q      <= 1'b0;
            gc_q        <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_d1_q    <= scl_s;
            sda_d1_q    <= sda_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_data_q   <= wr_data_d;
            sda_oe_q    <= sda_oe_d;
            wr_valid_q  <= wr_valid_d;
            rd_req_q    <= rd_req_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            gc_q        <= gc_d;
            start_det_q <= start_cond;
            stop_det_q  <= stop_cond;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign rd_req    = rd_req_q;
    assign op        = op_q;
    assign busy      = busy_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
`ifdef I2C_GENERAL_CALL_EN
    assign gc_hit    = gc_q;
`endif
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - directed bench for i2c_target_responder driving an open-drain bus model.
module tb_i2c_target_responder;
    localparam int Q = 6;
`ifdef I2C_GENERAL_CALL_EN
    localparam logic GC = 1'b1;
`else
    localparam logic GC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_drv = 1'b1;
    logic ctrl_low = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic sda_oe, wr_valid, rd_req, op, start_det, stop_det, busy;
    logic [7:0] wr_data;
`ifdef I2C_GENERAL_CALL_EN
    logic gc_hit;
`endif
    wire sda_bus = ~(ctrl_low | sda_oe);

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_drv), .sda_i(sda_bus),
        .sda_oe(sda_oe), .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
        .rd_data(rd_data), .op(op), .start_det(start_det), .stop_det(stop_det),
`ifdef I2C_GENERAL_CALL_EN
        .gc_hit(gc_hit),
`endif
        .busy(busy)
    );

    int cnt_start = 0, cnt_stop = 0, cnt_wv = 0, cnt_rr = 0;
    always @(negedge clk) begin
        if (start_det) cnt_start <= cnt_start + 1;
        if (stop_det)  cnt_stop  <= cnt_stop + 1;
        if (wr_valid)  cnt_wv    <= cnt_wv + 1;
        if (rd_req)    cnt_rr    <= cnt_rr + 1;
    end

    int n_vec = 0, n_bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drv_low, output logic smp);
        ctrl_low = drv_low;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        smp = sda_bus;
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        ctrl_low = 1'b0;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        ctrl_low = 1'b1;
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        ctrl_low = 1'b1;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        ctrl_low = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
        clock_bit(1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, input logic [7:0] next_rd, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b0, s);
            b[i] = s;
        end
        rd_data = next_rd;
        clock_bit(give_ack, s);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_aack;
        logic       exp_dack;
        int         exp_wv;
        logic [7:0] exp_wd;
        logic       exp_busy;
        logic       exp_gc;
    } vec_t;
    vec_t vecs[6];

    logic ack, s;
    logic [7:0] rb;
    int s0, p0, w0, r0;

    initial begin
        vecs[0] = '{8'h44, 8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h46, 8'h5A, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h44, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h44, 8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h12, GC,   GC,   GC ? 1 : 0, 8'h12, GC, GC};
        vecs[5] = '{8'hC4, 8'h44, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_op", op, 0);
        check("rst_start_det", start_det, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            s0 = cnt_start; p0 = cnt_stop; w0 = cnt_wv;
            bus_start();
            write_byte(vecs[i].addr, ack);
            check($sformatf("v%0d_addr_ack", i), ack, vecs[i].exp_aack);
            check($sformatf("v%0d_busy_mid", i), busy, vecs[i].exp_busy);
`ifdef I2C_GENERAL_CALL_EN
            check($sformatf("v%0d_gc_hit", i), gc_hit, vecs[i].exp_gc);
`endif
            write_byte(vecs[i].data, ack);
            check($sformatf("v%0d_data_ack", i), ack, vecs[i].exp_dack);
            if (vecs[i].exp_busy) check($sformatf("v%0d_op", i), op, 0);
            bus_stop();
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_wv_count", i), cnt_wv - w0, vecs[i].exp_wv);
            if (vecs[i].exp_wv > 0) check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_wd);
            check($sformatf("v%0d_busy_end", i), busy, 0);
            check($sformatf("v%0d_start_cnt", i), cnt_start - s0, 1);
            check($sformatf("v%0d_stop_cnt", i), cnt_stop - p0, 1);
`ifdef I2C_GENERAL_CALL_EN
            check($sformatf("v%0d_gc_clear", i), gc_hit, 0);
`endif
        end

        // Read: ACK first byte, NACK second.
        s0 = cnt_start; p0 = cnt_stop; r0 = cnt_rr;
        rd_data = 8'h3C;
        bus_start();
        write_byte(8'h45, ack);
        check("rd_addr_ack", ack, 1);
        check("rd_op", op, 1);
        check("rd_busy", busy, 1);
        read_byte(1'b1, 8'hF0, rb);
        check("rd_byte0", rb, 8'h3C);
        read_byte(1'b0, 8'h99, rb);
        check("rd_byte1", rb, 8'hF0);
        check("rd_nack_release", sda_oe, 0);
        bus_stop();
        repeat (4) @(negedge clk);
        check("rd_req_cnt", cnt_rr - r0, 2);
        check("rd_busy_end", busy, 0);
        check("rd_stop_cnt", cnt_stop - p0, 1);

        // Write then repeated START into a read.
        s0 = cnt_start; p0 = cnt_stop; w0 = cnt_wv;
        bus_start();
        write_byte(8'h44, ack);
        write_byte(8'h11, ack);
        check("rs_wr_ack", ack, 1);
        check("rs_wr_data", wr_data, 8'h11);
        check("rs_op_wr", op, 0);
        rd_data = 8'h77;
        bus_start();
        write_byte(8'h45, ack);
        check("rs_addr_ack", ack, 1);
        check("rs_op_rd", op, 1);
        read_byte(1'b0, 8'h00, rb);
        check("rs_rd_byte", rb, 8'h77);
        bus_stop();
        repeat (4) @(negedge clk);
        check("rs_wv_cnt", cnt_wv - w0, 1);
        check("rs_start_cnt", cnt_start - s0, 2);
        check("rs_stop_cnt", cnt_stop - p0, 1);

        // Repeated START mid-byte aborts the partial byte.
        w0 = cnt_wv;
        bus_start();
        write_byte(8'h44, ack);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        bus_start();
        write_byte(8'h44, ack);
        write_byte(8'h3C, ack);
        bus_stop();
        repeat (4) @(negedge clk);
        check("ab_wv_cnt", cnt_wv - w0, 1);
        check("ab_wr_data", wr_data, 8'h3C);

        // Reset while the target holds the address ACK.
        bus_start();
        rb = 8'h44;
        for (int i = 7; i >= 0; i--) clock_bit(~rb[i], s);
        ctrl_low = 1'b0;
        wait_q();
        check("rr_ack_driven", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rr_sda_async", sda_oe, 0);
        check("rr_busy", busy, 0);
        check("rr_wr_data", wr_data, 0);
        @(negedge clk);
        scl_drv = 1'b1;
        wait_q();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rr_post_sda", sda_oe, 0);
        check("rr_post_op", op, 0);
        check("rr_post_busy", busy, 0);
        w0 = cnt_wv;
        bus_start();
        write_byte(8'h44, ack);
        check("rr_new_ack", ack, 1);
        write_byte(8'h5A, ack);
        bus_stop();
        repeat (4) @(negedge clk);
        check("rr_new_wv", cnt_wv - w0, 1);
        check("rr_new_wr_data", wr_data, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
